// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: func codes, FSM states, iterative op selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  // Operation select presented on func
  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd1;
  localparam logic [2:0] FN_AND = 3'd2;
  localparam logic [2:0] FN_OR  = 3'd3;
  localparam logic [2:0] FN_XOR = 3'd4;
  localparam logic [2:0] FN_SHL = 3'd5;
  localparam logic [2:0] FN_SHR = 3'd6;
  localparam logic [2:0] FN_MUL = 3'd7;

  // Operation select for the iterative unit
  localparam logic [1:0] IT_SHL = 2'd0;
  localparam logic [1:0] IT_SHR = 2'd1;
  localparam logic [1:0] IT_MUL = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative engine for SHL/SHR (1 bit/cycle) and, with ALU_MUL_EN, shift-add multiply.
// Latency: loads on start, then one step per cycle until the down-counter empties; done flags the last step.
// Backpressure: none; the owning FSM only starts it when idle and holds the final value itself.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             done,
  output logic [WIDTH-1:0] res_nxt,
  output logic             cout_nxt
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_ONE = {{SHW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] val_q, val_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic [1:0]       op_q, op_d;

`ifdef ALU_MUL_EN
  // hi holds the upper product half; val doubles as the multiplier/low product half
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH:0]   msum;
`else
  // only the shift amount is needed without the multiplier
  logic [WIDTH-SHW-1:0] unused_opb_hi;
  assign unused_opb_hi = opb[WIDTH-1:SHW];
`endif

  // Load on start, otherwise advance one bit per cycle while the counter is non-zero
  always_comb begin
    val_d  = val_q;
    cnt_d  = cnt_q;
    cout_d = cout_q;
    op_d   = op_q;
`ifdef ALU_MUL_EN
    hi_d    = hi_q;
    mcand_d = mcand_q;
    msum    = '0;
`endif
    if (start) begin
      op_d   = op;
      val_d  = opa;
      cout_d = 1'b0;
      cnt_d  = {1'b0, opb[SHW-1:0]};
`ifdef ALU_MUL_EN
      if (op == IT_MUL) begin
        val_d   = opb;
        hi_d    = '0;
        mcand_d = opa;
        cnt_d   = (SHW+1)'(WIDTH);
      end
`endif
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
      case (op_q)
        IT_SHL: begin
          cout_d = val_q[WIDTH-1];
          val_d  = {val_q[WIDTH-2:0], 1'b0};
        end
        IT_SHR: begin
          cout_d = val_q[0];
          val_d  = {1'b0, val_q[WIDTH-1:1]};
        end
        default: begin
`ifdef ALU_MUL_EN
          // add multiplicand into the upper half when the current multiplier bit is set, then shift right
          msum   = {1'b0, hi_q} + (val_q[0] ? {1'b0, mcand_q} : '0);
          hi_d   = msum[WIDTH:1];
          val_d  = {msum[0], val_q[WIDTH-1:1]};
          cout_d = |msum[WIDTH:1];
`endif
        end
      endcase
    end
  end

  // Iteration state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q   <= '0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      op_q    <= IT_SHL;
`ifdef ALU_MUL_EN
      hi_q    <= '0;
      mcand_q <= '0;
`endif
    end else begin
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      op_q    <= op_d;
`ifdef ALU_MUL_EN
      hi_q    <= hi_d;
      mcand_q <= mcand_d;
`endif
    end
  end

  // The step being taken this cycle is the final one; its outcome is exposed directly
  assign done     = (cnt_q == CNT_ONE);
  assign res_nxt  = val_d;
  assign cout_nxt = cout_d;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: one op per in_valid/in_ready transfer, result and flags registered. ALU_MUL_EN enables func 7 multiply.
// Latency: 1 cycle for logic/add/sub/zero-shift, shamt+1 for shifts, WIDTH+1 for multiply.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE or in DONE while out_ready is high.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic             carryIn,
  input  logic [2:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             zero,
  output logic             negetive
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             load;
  logic [WIDTH:0]   sum;
  logic             it_start;
  logic [1:0]       it_op;
  logic             it_done;
  logic [WIDTH-1:0] it_res;
  logic             it_cout;

  assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (it_start),
    .op       (it_op),
    .opa      (inputA),
    .opb      (inputB),
    .done     (it_done),
    .res_nxt  (it_res),
    .cout_nxt (it_cout)
  );

  // Next-state, result and flag selection; an accept in DONE overrides the return to IDLE
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cout_d   = cout_q;
    load     = 1'b0;
    sum      = '0;
    it_start = 1'b0;
    it_op    = IT_SHL;

    case (state_q)
      ST_EXEC: begin
        if (it_done) begin
          state_d  = ST_DONE;
          result_d = it_res;
          cout_d   = it_cout;
          load     = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      state_d = ST_DONE;
      cout_d  = 1'b0;
      load    = 1'b1;
      case (func)
        FN_ADD: begin
          sum = {1'b0, inputA} + {1'b0, inputB} + (WIDTH+1)'(carryIn);
          {cout_d, result_d} = sum;
        end
        FN_SUB: begin
          sum = {1'b0, inputA} + {1'b0, ~inputB} + (WIDTH+1)'(carryIn);
          {cout_d, result_d} = sum;
        end
        FN_AND: result_d = inputA & inputB;
        FN_OR:  result_d = inputA | inputB;
        FN_XOR: result_d = inputA ^ inputB;
        FN_SHL, FN_SHR: begin
          if (inputB[SHW-1:0] == '0) begin
            result_d = inputA;
          end else begin
            state_d  = ST_EXEC;
            it_start = 1'b1;
            it_op    = (func == FN_SHL) ? IT_SHL : IT_SHR;
            load     = 1'b0;
          end
        end
        default: begin
          // FN_MUL
`ifdef ALU_MUL_EN
          state_d  = ST_EXEC;
          it_start = 1'b1;
          it_op    = IT_MUL;
          load     = 1'b0;
`else
          result_d = '0;
`endif
        end
      endcase
    end

    zero_d      = load ? (result_d == '0)    : zero_q;
    neg_d       = load ? result_d[WIDTH-1]   : neg_q;
    out_valid_d = (state_d == ST_DONE);
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      cout_q      <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carryOut  = cout_q;
  assign zero      = zero_q;
  assign negetive  = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=8; expectations are hand-computed constants.
// Latency: measured from the accepting edge to the first cycle out_valid is seen.
// Backpressure: exercises held results under out_ready=0 and accept-on-consume.
module tb_alu_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] inputA;
  logic [7:0] inputB;
  logic       carryIn;
  logic [2:0] func;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carryOut;
  logic       zero;
  logic       negetive;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inputA    (inputA),
    .inputB    (inputB),
    .carryIn   (carryIn),
    .func      (func),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carryOut  (carryOut),
    .zero      (zero),
    .negetive  (negetive)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // advance one clock, landing 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [7:0] a,
                        input logic [7:0] b, input logic ci, input int lat,
                        input logic [7:0] r, input logic co, input logic z,
                        input logic n, input bit consume);
    int  cyc;
    bit  rdy_busy;
    check({tag, ".in_ready"}, in_ready, 1);
    func = f; inputA = a; inputB = b; carryIn = ci; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    inputA = ~a; inputB = ~b; carryIn = ~ci;
    cyc = 1;
    rdy_busy = 1'b0;
    while (!out_valid && cyc < 40) begin
      if (in_ready) rdy_busy = 1'b1;
      tick();
      cyc++;
    end
    check({tag, ".lat"},  16'(cyc), 16'(lat));
    check({tag, ".busy_rdy"}, rdy_busy, 0);
    check({tag, ".res"},  result,   r);
    check({tag, ".cout"}, carryOut, co);
    check({tag, ".zero"}, zero,     z);
    check({tag, ".neg"},  negetive, n);
    if (consume) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, ".drain"}, out_valid, 0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; inputA = '0; inputB = '0; carryIn = 1'b0;
    func = FN_ADD; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    check("rst.out_valid", out_valid, 0);
    check("rst.result",    result,    0);
    check("rst.cout",      carryOut,  0);
    check("rst.zero",      zero,      0);
    check("rst.neg",       negetive,  0);
    check("rst.in_ready",  in_ready,  1);

    //     tag       func    A      B      ci  lat  res    co  z  n  consume
    run_op("add",    FN_ADD, 8'h01, 8'hFE, 1, 1, 8'h00, 1, 1, 0, 1);
    run_op("add2",   FN_ADD, 8'hFF, 8'h00, 0, 1, 8'hFF, 0, 0, 1, 1);
    run_op("sub",    FN_SUB, 8'h0E, 8'hEE, 1, 1, 8'h20, 0, 0, 0, 1);
    run_op("sub2",   FN_SUB, 8'h50, 8'h20, 1, 1, 8'h30, 1, 0, 0, 1);
    run_op("or",     FN_OR,  8'hA0, 8'h05, 0, 1, 8'hA5, 0, 0, 1, 1);
    run_op("xor",    FN_XOR, 8'hFF, 8'hFF, 1, 1, 8'h00, 0, 1, 0, 1);
    run_op("shl7",   FN_SHL, 8'h01, 8'h07, 0, 8, 8'h80, 0, 0, 1, 1);
    run_op("shl3",   FN_SHL, 8'hF0, 8'h03, 0, 4, 8'h80, 1, 0, 1, 1);
    run_op("shr1",   FN_SHR, 8'h03, 8'h01, 0, 2, 8'h01, 1, 0, 0, 1);
    run_op("shr0",   FN_SHR, 8'h03, 8'h08, 0, 1, 8'h03, 0, 0, 0, 0);

    // result left unconsumed: must stay put and block new ops
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold.valid", out_valid, 1);
      check("hold.res",   result,    8'h03);
      check("hold.rdy",   in_ready,  0);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; func = FN_AND; inputA = 8'hFF; inputB = 8'h0F; carryIn = 1'b0;
    #1;
    check("b2b.in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b.valid", out_valid, 1);
    check("b2b.res",   result,    8'h0F);
    check("b2b.cout",  carryOut,  0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset pulse in the middle of a long shift
    in_valid = 1'b1; func = FN_SHL; inputA = 8'h01; inputB = 8'h07;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("mid.busy", in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid.valid", out_valid, 0);
    check("mid.res",   result,    0);
    check("mid.cout",  carryOut,  0);
    check("mid.zero",  zero,      0);
    check("mid.neg",   negetive,  0);
    check("mid.rdy",   in_ready,  1);
    for (int i = 0; i < 8; i++) tick();
    check("mid.no_result", out_valid, 0);

`ifdef ALU_MUL_EN
    run_op("mul",    FN_MUL, 8'h0F, 8'h11, 0, 9, 8'hFF, 0, 0, 1, 1);
    run_op("mul_ov", FN_MUL, 8'hFF, 8'hFF, 0, 9, 8'h01, 1, 0, 0, 1);
`else
    run_op("mul",    FN_MUL, 8'h0F, 8'h11, 0, 1, 8'h00, 0, 1, 0, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
